// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame geometry and the
// parity rule used by both link directions.
package uart_pkg;

  typedef logic [2:0] uart_state_t;

  localparam uart_state_t S_IDLE      = 3'd0;
  localparam uart_state_t S_START     = 3'd1;
  localparam uart_state_t S_DATA      = 3'd2;
  localparam uart_state_t S_PARITY    = 3'd3;
  localparam uart_state_t S_STOP      = 3'd4;
  localparam uart_state_t S_WAIT_IDLE = 3'd5;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 11;

  // Parity bit a transmitter puts on the line for this byte.
  function automatic logic parity_bit(input logic [UART_DATA_BITS-1:0] d,
                                      input logic odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for asynchronous inputs; resets to 1 so an idle
// serial line does not look like a start edge coming out of reset.
module uart_rx_sync (
  input  logic clk_i,
  input  logic reset_i,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receiver: start, 8 data bits LSB first, parity, stop.
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle, waiting for a falling edge on rxs
// START     | confirm start bit at its centre (false-start rejection)
// DATA      | sample 8 data bits at bit centres, shifting in LSB first
// PARITY    | sample parity bit and latch the mismatch flag
// STOP      | sample stop bit; deliver byte or flag framing error
// WAIT_IDLE | framing error seen; hold until the line returns high
module uart_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                      uart_clock,
  input  logic                      reset,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] data,
  output logic                      dataValid,
  output logic                      parityError,
  output logic                      framingError,
  output logic                      busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [2:0]    BIT_LAST  = 3'(UART_DATA_BITS - 1);

  logic rxs;
  logic rxs_prev_q;

  uart_state_t state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_DATA_BITS-1:0] data_q, data_d;
  logic perr_q, perr_d;
  logic valid_q, valid_d;
  logic perr_out_q, perr_out_d;
  logic ferr_q, ferr_d;

  uart_rx_sync u_sync (
    .clk_i   (uart_clock),
    .reset_i (reset),
    .async_i (rx),
    .sync_o  (rxs)
  );

  always_ff @(posedge uart_clock) begin
    if (reset) begin
      rxs_prev_q <= 1'b1;
      state_q    <= S_IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      perr_q     <= 1'b0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rxs_prev_q <= rxs;
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      perr_q     <= perr_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_q     <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (!rxs && rxs_prev_q) state_d = S_START;
      S_START:     if (tick_q == TICK_HALF) state_d = rxs ? S_IDLE : S_DATA;
      S_DATA:      if (tick_q == TICK_LAST && bit_q == BIT_LAST) state_d = S_PARITY;
      S_PARITY:    if (tick_q == TICK_LAST) state_d = S_STOP;
      S_STOP:      if (tick_q == TICK_LAST) state_d = rxs ? S_IDLE : S_WAIT_IDLE;
      S_WAIT_IDLE: if (rxs) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Datapath next-state; delivery strobes default low so they last one cycle.
  always_comb begin
    tick_d     = tick_q + TICK_ONE;
    bit_d      = bit_q;
    shift_d    = shift_q;
    data_d     = data_q;
    perr_d     = perr_q;
    valid_d    = 1'b0;
    perr_out_d = 1'b0;
    ferr_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tick_d = '0;
        bit_d  = '0;
      end
      S_START: begin
        if (tick_q == TICK_HALF) begin
          tick_d = '0;
          bit_d  = '0;
        end
      end
      S_DATA: begin
        if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          shift_d = {rxs, shift_q[UART_DATA_BITS-1:1]};
          bit_d   = bit_q + 3'd1;
        end
      end
      S_PARITY: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          perr_d = parity_bit(shift_q, PARITY_ODD) != rxs;
        end
      end
      S_STOP: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (rxs) begin
            data_d     = shift_q;
            valid_d    = 1'b1;
            perr_out_d = perr_q;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: tick_d = '0;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
  end

  assign data         = data_q;
  assign dataValid    = valid_q;
  assign parityError  = perr_out_q;
  assign framingError = ferr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench: an even-parity and an odd-parity receiver share one
// serial line; expected bytes and parity flags come from a frame-level model.
module tb_uart_receiver;

  localparam int OS = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx = 1'b1;
  logic [7:0] data_w [2];
  logic dv [2];
  logic pe [2];
  logic fe [2];
  logic bz [2];

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t mon_e;
  bit   mon_have;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int vcnt [2] = '{0, 0};
  int fcnt [2] = '{0, 0};
  int lat_cyc = -1;
  int fall_cyc = 0;
  bit lat_arm = 1'b0;
  logic [7:0] last_good = 8'h00;
  int v_snap [2];
  int f_snap [2];

  uart_receiver #(.OVERSAMPLE(OS), .PARITY_ODD(1'b0)) dut_even (
    .uart_clock(clk), .reset(reset), .rx(rx), .data(data_w[0]),
    .dataValid(dv[0]), .parityError(pe[0]), .framingError(fe[0]), .busy(bz[0]));

  uart_receiver #(.OVERSAMPLE(OS), .PARITY_ODD(1'b1)) dut_odd (
    .uart_clock(clk), .reset(reset), .rx(rx), .data(data_w[1]),
    .dataValid(dv[1]), .parityError(pe[1]), .framingError(fe[1]), .busy(bz[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Even mode wants an even number of ones over data+parity, odd mode an odd number.
  function automatic logic model_perr(input logic [7:0] d, input logic par, input bit odd);
    int ones;
    ones = $countones(d) + int'(par);
    return odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
  endfunction

  function automatic logic even_par(input logic [7:0] d);
    return ($countones(d) % 2) == 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (fe[i] === 1'b1) fcnt[i]++;
      if (dv[i] === 1'b1) begin
        vcnt[i]++;
        mon_have = 1'b0;
        mon_e = '0;
        if (i == 0 && q0.size() > 0) begin mon_e = q0.pop_front(); mon_have = 1'b1; end
        if (i == 1 && q1.size() > 0) begin mon_e = q1.pop_front(); mon_have = 1'b1; end
        check("valid_expected", 32'(mon_have), 32'd1);
        if (mon_have) begin
          check("data", 32'(data_w[i]), 32'(mon_e.d));
          check("parity_error", 32'(pe[i]), 32'(mon_e.pe));
        end
        if (i == 0 && lat_arm) begin
          lat_cyc = cyc;
          lat_arm = 1'b0;
        end
      end else begin
        check("perr_without_valid", 32'(pe[i]), 32'd0);
      end
    end
  end

  // Drives one frame starting at a negedge; jitter moves each inner bit edge by -1..+1.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input bit jit);
    logic [10:0] bits;
    exp_t e;
    int off_prev, off_next, dur;
    bits = {stp, par, d, 1'b0};
    if (stp) begin
      e.d = d; e.pe = model_perr(d, par, 1'b0); q0.push_back(e);
      e.pe = model_perr(d, par, 1'b1); q1.push_back(e);
      last_good = d;
    end
    off_prev = 0;
    for (int k = 0; k < 11; k++) begin
      rx = bits[k];
      if (k == 0) fall_cyc = cyc;
      off_next = (jit && k < 10) ? (int'($urandom_range(0, 2)) - 1) : 0;
      dur = OS + off_next - off_prev;
      off_prev = off_next;
      repeat (dur) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    for (int i = 0; i < 2; i++) begin
      v_snap[i] = vcnt[i];
      f_snap[i] = fcnt[i];
    end
  endtask

  initial begin
    logic [7:0] rd;
    logic rp;

    reset = 1'b1;
    rx = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("reset_data", 32'(data_w[i]), 32'd0);
      check("reset_valid", 32'(dv[i]), 32'd0);
      check("reset_perr", 32'(pe[i]), 32'd0);
      check("reset_ferr", 32'(fe[i]), 32'd0);
      check("reset_busy", 32'(bz[i]), 32'd0);
    end
    reset = 1'b0;
    idle(20);

    // Clean frame and end-to-end latency from the rx falling edge
    lat_arm = 1'b1;
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    idle(8);
    check("latency", 32'(lat_cyc - fall_cyc), 32'd171);
    check("clean_count", 32'(vcnt[0]), 32'd1);

    // Wrong parity for even mode, right parity for odd mode
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
    idle(8);
    check("hold_after_3c", 32'(data_w[1]), 32'h3C);

    // False start: short low pulse
    snap();
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("false_start_busy", 32'(bz[i]), 32'd0);
      check("false_start_valid", 32'(vcnt[i]), 32'(v_snap[i]));
      check("false_start_ferr", 32'(fcnt[i]), 32'(f_snap[i]));
    end
    send_frame(8'h55, even_par(8'h55), 1'b1, 1'b0);
    idle(8);

    // Framing error followed by a held-low line
    snap();
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    for (int i = 0; i < 2; i++) check("break_busy", 32'(bz[i]), 32'd1);
    repeat (20) @(negedge clk);
    for (int i = 0; i < 2; i++) check("break_busy_late", 32'(bz[i]), 32'd1);
    rx = 1'b1;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("break_release_busy", 32'(bz[i]), 32'd0);
      check("framing_pulses", 32'(fcnt[i]), 32'(f_snap[i] + 1));
      check("framing_no_valid", 32'(vcnt[i]), 32'(v_snap[i]));
      check("framing_data_kept", 32'(data_w[i]), 32'(last_good));
    end

    // Back-to-back frames with edge jitter
    idle(10);
    snap();
    send_frame(8'h01, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
    send_frame(8'h80, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
    send_frame(8'h7E, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
    idle(10);
    for (int i = 0; i < 2; i++) check("b2b_count", 32'(vcnt[i]), 32'(v_snap[i] + 3));

    // Random bytes and parity bits with random gaps
    for (int n = 0; n < 6; n++) begin
      rd = 8'($urandom);
      rp = 1'($urandom_range(0, 1));
      send_frame(rd, rp, 1'b1, n[0]);
      idle(int'($urandom_range(0, 5)));
    end
    idle(10);

    // Reset in the middle of data bit 4
    rx = 1'b0;
    repeat (OS + 4 * OS + OS / 2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("midreset_data", 32'(data_w[i]), 32'd0);
      check("midreset_valid", 32'(dv[i]), 32'd0);
      check("midreset_ferr", 32'(fe[i]), 32'd0);
      check("midreset_busy", 32'(bz[i]), 32'd0);
    end
    repeat (2) @(negedge clk);
    rx = 1'b1;
    reset = 1'b0;
    repeat (20) @(negedge clk);
    snap();
    send_frame(8'hC3, even_par(8'hC3), 1'b1, 1'b0);
    idle(10);
    for (int i = 0; i < 2; i++) begin
      check("post_reset_count", 32'(vcnt[i]), 32'(v_snap[i] + 1));
      check("post_reset_data", 32'(data_w[i]), 32'hC3);
    end

    for (int n = 0; n < 1000 && (q0.size() > 0 || q1.size() > 0); n++) @(negedge clk);
    check("pending_even", 32'(q0.size()), 32'd0);
    check("pending_odd", 32'(q1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
